// File: rtl/store_buffer.sv
// Two-level store buffer: a flushable speculative queue feeds a non-flushable commit queue that drains in order to the D$.
// One cycle write->commit and commit->data_req_o; ready_o / commit_ready_o drop while the respective queue is full.
module store_buffer #(
  parameter int SPEC_DEPTH   = 4,
  parameter int COMMIT_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [55:0] paddr_i,
  input  logic [63:0] data_i,
  input  logic [7:0]  be_i,
  input  logic [1:0]  data_size_i,
  output logic        ready_o,
  input  logic        commit_i,
  output logic        commit_ready_o,
  output logic        no_st_pending_o,
  output logic        store_buffer_empty_o,
  input  logic [11:0] page_offset_i,
  output logic        page_offset_matches_o,
  output logic        data_req_o,
  output logic [55:0] address_o,
  output logic [63:0] wdata_o,
  output logic [7:0]  be_o,
  output logic [1:0]  size_o,
  input  logic        data_gnt_i
);
  localparam int SPW = $clog2(SPEC_DEPTH);
  localparam int CPW = $clog2(COMMIT_DEPTH);

  typedef struct packed {
    logic [55:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [1:0]  size;
  } entry_t;

  entry_t                 spec_mem [SPEC_DEPTH];
  entry_t                 com_mem  [COMMIT_DEPTH];
  logic [SPEC_DEPTH-1:0]  spec_vld;
  logic [COMMIT_DEPTH-1:0] com_vld;
  logic [SPW-1:0]         spec_rptr, spec_wptr;
  logic [SPW:0]           spec_count;
  logic [CPW-1:0]         com_rptr, com_wptr;
  logic [CPW:0]           com_count;
  logic                   spec_push, spec_pop, com_pop;
  entry_t                 com_head;
  logic                   unused_offset_lsbs;

  assign ready_o              = spec_count != (SPW+1)'(SPEC_DEPTH);
  assign commit_ready_o       = com_count != (CPW+1)'(COMMIT_DEPTH);
  assign data_req_o           = com_count != '0;
  assign no_st_pending_o      = com_count == '0;
  assign store_buffer_empty_o = (spec_count == '0) && (com_count == '0);

  // A flush wins over a same-cycle new store, but not over a same-cycle commit.
  assign spec_push = valid_i && ready_o && !flush_i;
  assign spec_pop  = commit_i && commit_ready_o && (spec_count != '0);
  assign com_pop   = data_req_o && data_gnt_i;

  assign com_head  = com_mem[com_rptr];
  assign address_o = com_head.paddr;
  assign wdata_o   = com_head.data;
  assign be_o      = com_head.be;
  assign size_o    = com_head.size;

  assign unused_offset_lsbs = ^page_offset_i[2:0];

  always_ff @(posedge clk_i) begin
    if (spec_push) spec_mem[spec_wptr] <= '{paddr_i, data_i, be_i, data_size_i};
    if (spec_pop)  com_mem[com_wptr]   <= spec_mem[spec_rptr];
  end

  // Push and pop never target the same slot: push needs not-full, pop needs not-empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spec_rptr  <= '0;
      spec_wptr  <= '0;
      spec_count <= '0;
      spec_vld   <= '0;
      com_rptr   <= '0;
      com_wptr   <= '0;
      com_count  <= '0;
      com_vld    <= '0;
    end else begin
      if (flush_i) begin
        spec_rptr  <= '0;
        spec_wptr  <= '0;
        spec_count <= '0;
        spec_vld   <= '0;
      end else begin
        if (spec_push) begin
          spec_vld[spec_wptr] <= 1'b1;
          spec_wptr           <= spec_wptr + 1'b1;
        end
        if (spec_pop) begin
          spec_vld[spec_rptr] <= 1'b0;
          spec_rptr           <= spec_rptr + 1'b1;
        end
        spec_count <= spec_count + (SPW+1)'(spec_push) - (SPW+1)'(spec_pop);
      end
      if (spec_pop) begin
        com_vld[com_wptr] <= 1'b1;
        com_wptr          <= com_wptr + 1'b1;
      end
      if (com_pop) begin
        com_vld[com_rptr] <= 1'b0;
        com_rptr          <= com_rptr + 1'b1;
      end
      com_count <= com_count + (CPW+1)'(spec_pop) - (CPW+1)'(com_pop);
    end
  end

  always_comb begin
    page_offset_matches_o = 1'b0;
    for (int i = 0; i < SPEC_DEPTH; i++)
      if (spec_vld[i] && spec_mem[i].paddr[11:3] == page_offset_i[11:3])
        page_offset_matches_o = 1'b1;
    for (int i = 0; i < COMMIT_DEPTH; i++)
      if (com_vld[i] && com_mem[i].paddr[11:3] == page_offset_i[11:3])
        page_offset_matches_o = 1'b1;
  end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: commits push the expected D$ write, grants pop and compare.
module tb_store_buffer;
  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, commit_i, data_gnt_i;
  logic [55:0] paddr_i;
  logic [63:0] data_i;
  logic [7:0]  be_i;
  logic [1:0]  data_size_i;
  logic [11:0] page_offset_i;
  logic        ready_o, commit_ready_o, no_st_pending_o, store_buffer_empty_o;
  logic        page_offset_matches_o, data_req_o;
  logic [55:0] address_o;
  logic [63:0] wdata_o;
  logic [7:0]  be_o;
  logic [1:0]  size_o;

  always #5 clk_i = ~clk_i;

  store_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i), .data_size_i(data_size_i),
    .ready_o(ready_o), .commit_i(commit_i), .commit_ready_o(commit_ready_o),
    .no_st_pending_o(no_st_pending_o), .store_buffer_empty_o(store_buffer_empty_o),
    .page_offset_i(page_offset_i), .page_offset_matches_o(page_offset_matches_o),
    .data_req_o(data_req_o), .address_o(address_o), .wdata_o(wdata_o),
    .be_o(be_o), .size_o(size_o), .data_gnt_i(data_gnt_i)
  );

  typedef struct packed {
    logic [55:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [1:0]  size;
  } ent_t;

  ent_t spec_m[$];
  ent_t com_m[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   dut_drains = 0;

  task automatic chk(input string tag, input logic [129:0] got, input logic [129:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_match(input logic [11:0] off);
    model_match = 1'b0;
    foreach (spec_m[i]) if (spec_m[i].paddr[11:3] == off[11:3]) model_match = 1'b1;
    foreach (com_m[i])  if (com_m[i].paddr[11:3] == off[11:3])  model_match = 1'b1;
  endfunction

  function automatic ent_t mk(input int i);
    ent_t e;
    e.paddr = 56'h00_0040_0000_0000 + 56'(i * 64);
    e.data  = {32'hCAFE_0000 + 32'(i), 32'h1234_0000 + 32'(i)};
    e.be    = 8'(8'hF0 ^ i);
    e.size  = 2'(i);
    return e;
  endfunction

  task automatic idle();
    valid_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0;
  endtask

  task automatic drive_store(input ent_t e);
    valid_i = 1'b1; paddr_i = e.paddr; data_i = e.data; be_i = e.be; data_size_i = e.size;
  endtask

  // Checks outputs against the model for the current cycle, then advances model and DUT one edge.
  task automatic step();
    logic do_push, do_commit, do_drain;
    ent_t cur;
    #1;
    chk("ready", ready_o, spec_m.size() != 4);
    chk("commit_ready", commit_ready_o, com_m.size() != 4);
    chk("data_req", data_req_o, com_m.size() != 0);
    chk("no_st_pending", no_st_pending_o, com_m.size() == 0);
    chk("empty", store_buffer_empty_o, spec_m.size() == 0 && com_m.size() == 0);
    chk("match", page_offset_matches_o, model_match(page_offset_i));
    if (com_m.size() != 0)
      chk("payload", {address_o, wdata_o, be_o, size_o}, com_m[0]);
    if (data_req_o && data_gnt_i) dut_drains++;
    cur = '{paddr_i, data_i, be_i, data_size_i};
    if (rst_i) begin
      spec_m.delete();
      com_m.delete();
    end else begin
      do_drain  = com_m.size() != 0 && data_gnt_i;
      do_commit = commit_i && com_m.size() != 4 && spec_m.size() != 0;
      do_push   = valid_i && spec_m.size() != 4 && !flush_i;
      if (do_drain) void'(com_m.pop_front());
      if (do_commit) com_m.push_back(spec_m.pop_front());
      if (flush_i) spec_m.delete();
      else if (do_push) spec_m.push_back(cur);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    ent_t e, r;
    int   d0;
    idle();
    data_gnt_i = 1'b0; page_offset_i = '0;
    paddr_i = '0; data_i = '0; be_i = '0; data_size_i = '0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_commit_ready", commit_ready_o, 1'b1);
    chk("rst_req", data_req_o, 1'b0);
    chk("rst_nopend", no_st_pending_o, 1'b1);
    chk("rst_empty", store_buffer_empty_o, 1'b1);
    chk("rst_match", page_offset_matches_o, 1'b0);

    // Single store, commit one cycle later, grant tied high.
    e = '{56'h8000_1008, 64'hDEAD_BEEF, 8'h0F, 2'd2};
    drive_store(e); step();
    idle(); commit_i = 1'b1; data_gnt_i = 1'b1; d0 = dut_drains; step();
    commit_i = 1'b0;
    chk("t1_req", data_req_o, 1'b1);
    chk("t1_addr", address_o, 56'h8000_1008);
    chk("t1_data", wdata_o, 64'hDEAD_BEEF);
    step();
    chk("t1_req_low", data_req_o, 1'b0);
    chk("t1_nopend", no_st_pending_o, 1'b1);
    chk("t1_drains", dut_drains - d0, 1);

    // Fill spec queue, drop a fifth, commit all with no grant, then drain in order.
    data_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin drive_store(mk(i)); step(); end
    chk("t2_full", ready_o, 1'b0);
    drive_store(mk(9)); step();
    idle();
    for (int i = 0; i < 4; i++) begin commit_i = 1'b1; step(); end
    commit_i = 1'b0;
    chk("t2_cfull", commit_ready_o, 1'b0);
    chk("t2_spec_empty", ready_o, 1'b1);
    data_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin chk("t2_order", address_o, mk(i).paddr); step(); end
    chk("t2_done", no_st_pending_o, 1'b1);

    // Flush and commit in the same cycle: only the oldest store survives.
    data_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin drive_store(mk(10 + i)); step(); end
    idle(); flush_i = 1'b1; commit_i = 1'b1; data_gnt_i = 1'b1; d0 = dut_drains; step();
    idle();
    chk("t3_addr", address_o, mk(10).paddr);
    repeat (3) step();
    chk("t3_drains", dut_drains - d0, 1);
    chk("t3_empty", store_buffer_empty_o, 1'b1);

    // Full commit queue held without grant for 10 cycles.
    data_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin drive_store(mk(20 + i)); step(); end
    idle();
    for (int i = 0; i < 4; i++) begin commit_i = 1'b1; step(); end
    commit_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold", {address_o, wdata_o, be_o, size_o}, mk(20));
      chk("t4_req", data_req_o, 1'b1);
      chk("t4_pend", no_st_pending_o, 1'b0);
      step();
    end
    data_gnt_i = 1'b1;
    repeat (4) step();

    // Load hazard on page offset.
    data_gnt_i = 1'b0;
    e = '{56'h00_0000_8765_40A8, 64'h55, 8'hFF, 2'd3};
    drive_store(e); step(); idle();
    page_offset_i = 12'h0AC; #1;
    chk("t5_hit", page_offset_matches_o, 1'b1);
    page_offset_i = 12'h0B0; #1;
    chk("t5_miss", page_offset_matches_o, 1'b0);
    page_offset_i = 12'h0AC;
    commit_i = 1'b1; step(); commit_i = 1'b0;
    chk("t5_hit_commit", page_offset_matches_o, 1'b1);
    data_gnt_i = 1'b1; step(); step();
    chk("t5_gone", page_offset_matches_o, 1'b0);

    // Reset with committed stores pending.
    data_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin drive_store(mk(40 + i)); step(); end
    idle();
    for (int i = 0; i < 2; i++) begin commit_i = 1'b1; step(); end
    idle(); rst_i = 1'b1; step(); rst_i = 1'b0;
    data_gnt_i = 1'b1;
    chk("t6_req", data_req_o, 1'b0);
    chk("t6_empty", store_buffer_empty_o, 1'b1);

    // Random traffic against the queue model.
    for (int c = 0; c < 10000; c++) begin
      r.paddr = {24'($urandom), 32'($urandom)};
      r.paddr[11:3] = 9'($urandom_range(0, 7));
      r.data  = {$urandom, $urandom};
      r.be    = 8'($urandom);
      r.size  = 2'($urandom);
      drive_store(r);
      valid_i       = 1'($urandom_range(0, 1));
      commit_i      = 1'($urandom_range(0, 1));
      flush_i       = $urandom_range(0, 19) == 0;
      rst_i         = $urandom_range(0, 1999) == 0;
      data_gnt_i    = $urandom_range(0, 9) < 6;
      page_offset_i = {6'd0, 3'($urandom_range(0, 7)), 3'($urandom)};
      step();
    end

    idle(); flush_i = 1'b1; data_gnt_i = 1'b1; step();
    idle(); repeat (5) step();
    chk("final_empty", store_buffer_empty_o, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Two-level store buffer in the load/store unit that holds stores between execution and the data cache. Stores enter a flushable speculative queue after address translation. The commit stage promotes them into a non-flushable commit queue via `commit_i` / `commit_ready_o`. The commit queue drains to the D$ write port in order. The block reports `no_st_pending_o` and `commit_ready_o`, which the commit stage uses to stall fences, `sfence.vma` and stores.

## Interface
- `SPEC_DEPTH`, default 4: speculative queue entries (power of two, ≥2).
- `COMMIT_DEPTH`, default 4: commit queue entries (power of two, ≥2).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. Synchronous, active-high (already decided).
- `flush_i`  in  1  pipeline flush; drops all speculative entries.
- `valid_i`  in  1  new store from LSU.
- `paddr_i`  in  56  physical address.
- `data_i`  in  64  store data, already lane-aligned.
- `be_i`  in  8  byte enables.
- `data_size_i`  in  2  log2 of access bytes.
- `ready_o`  out  1  speculative queue not full.
- `commit_i`  in  1  commit oldest speculative store.
- `commit_ready_o`  out  1  commit queue not full.
- `no_st_pending_o`  out  1  commit queue empty and no request in flight.
- `store_buffer_empty_o`  out  1  both queues empty.
- `page_offset_i`  in  12  load address page offset, for the hazard check.
- `page_offset_matches_o`  out  1  a valid entry in either queue has `paddr[11:3] == page_offset_i[11:3]`.
- `data_req_o`  out  1  D$ write request.
- `address_o`  out  56  D$ write address.
- `wdata_o`  out  64  D$ write data.
- `be_o`  out  8  D$ byte enables.
- `size_o`  out  2  D$ size.
- `data_gnt_i`  in  1  D$ accepted the current request.

## Operation
- Each queue is a circular buffer with read pointer, write pointer and occupancy count (width `$clog2(DEPTH)+1`). Pointers wrap modulo DEPTH.
- Speculative write: when `valid_i && ready_o`, store `{paddr,data,be,size}` at the spec write pointer. When `valid_i && !ready_o`, the store is dropped; this is an LSU protocol violation, flagged by a bench assertion.
- Commit: when `commit_i && commit_ready_o && spec_count != 0`, copy the spec head to the commit write pointer and advance both pointers.
  - `commit_i` with an empty spec queue is ignored (assertion).
  - `commit_i` with `!commit_ready_o` is ignored; the commit stage never does this.
- Drain: `data_req_o = (commit_count != 0)`. `address_o`, `wdata_o`, `be_o` and `size_o` are driven combinationally from the commit head. On `data_req_o && data_gnt_i`, pop the head.
- Flush: on `flush_i`, set spec read pointer, write pointer and count to 0. The commit queue is unaffected.
- Simultaneous events, same cycle:
  - Write + commit: spec count unchanged.
  - Commit + drain: commit count unchanged.
  - Flush + commit: the commit takes effect (entry moves to the commit queue), then the remaining spec entries are cleared.
  - Flush + `valid_i`: the new store is dropped.
- Status outputs:
  - `ready_o = spec_count != SPEC_DEPTH`.
  - `commit_ready_o = commit_count != COMMIT_DEPTH`. Both come from registered counts; a same-cycle pop does not raise them.
  - `no_st_pending_o = commit_count == 0`.
  - `store_buffer_empty_o = spec_count == 0 && commit_count == 0`.
- Reset: all pointers and counts are 0, all entry valid state is cleared. Resulting outputs: `ready_o=1`, `commit_ready_o=1`, `data_req_o=0`, `no_st_pending_o=1`, `store_buffer_empty_o=1`, `page_offset_matches_o=0`. Data payload registers are not reset.
- Reset asserted mid-operation discards all entries, including committed ones, without issuing further requests.

## Timing
- A store written in cycle N can be committed in cycle N+1 at the earliest (spec count updates at the edge).
- A store committed in cycle N raises `data_req_o` in cycle N+1 when the commit queue was empty.
- `data_req_o` and its payload stay stable until `data_gnt_i`. Back-to-back grants give one store per cycle.
- `page_offset_matches_o` is purely combinational from `page_offset_i` and the registered entry state, with zero latency. Entries popped or flushed in cycle N stop matching from N+1.
- Throughput: one write, one commit and one drain per cycle.

## Test plan
- Reset, then write one store (`paddr=0x8000_1008`, `data=0xDEAD_BEEF`, `be=0x0F`), commit one cycle later, `data_gnt_i` tied to 1 → `data_req_o` high exactly one cycle with matching payload; `no_st_pending_o` back to 1 the cycle after the grant.
- Write 4 stores without commit → `ready_o=0` after the 4th. A 5th `valid_i` is dropped. Commit all 4 with `data_gnt_i=0` → `commit_ready_o=0`. Then grant 4 cycles → drain order matches write order.
- Write 3 stores, assert `flush_i` and `commit_i` in the same cycle → exactly 1 store reaches the D$; `store_buffer_empty_o=1` after the drain.
- Fill the commit queue, hold `data_gnt_i=0` for 10 cycles → `data_req_o` and payload stable for all 10 cycles; `no_st_pending_o=0` throughout.
- Store at `paddr=0x...0A8`, load page offset `0x0AC` → match=1; offset `0x0B0` → match=0; after drain, offset `0x0AC` → match=0.
- Random write/commit/flush/grant for 10k cycles against a queue reference model → D$ write sequence equals the committed-store sequence; pointers wrap correctly.
